// File: rtl/scaler_pkg.sv
// Shared constants, types and helpers for the scaler multiplier arbiter.
package scaler_pkg;

  // Q16 fixed point: the multiplier returns (feature * scaler) >>> FRAC_BITS.
  localparam int FRAC_BITS         = 16;
  localparam int DEF_NUM_REQ       = 4;
  localparam int DEF_FEATURE_WIDTH = 32;
  localparam int DEF_SCALER_WIDTH  = 32;

  // Width of a requester index; kept at least 1 bit so the tag is never zero-width.
  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  localparam int DEF_ID_W = id_width(DEF_NUM_REQ);

  // One returned result at the default configuration.
  typedef struct packed {
    logic [DEF_ID_W-1:0]          id;
    logic [DEF_FEATURE_WIDTH-1:0] data;
  } rsp_t;

endpackage

// File: rtl/scaler_mult_arbiter_if.sv
// Request/response bundle between the accumulators (master) and the arbiter (slave).
interface scaler_mult_arbiter_if
  import scaler_pkg::*;
#(
  parameter int NUM_REQ       = DEF_NUM_REQ,
  parameter int FEATURE_WIDTH = DEF_FEATURE_WIDTH,
  parameter int SCALER_WIDTH  = DEF_SCALER_WIDTH
);
  localparam int ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ-1:0]               req_ready;
  logic [NUM_REQ*FEATURE_WIDTH-1:0] req_feature;
  logic [NUM_REQ*SCALER_WIDTH-1:0]  req_scaler;
  logic                             rsp_valid;
  logic                             rsp_ready;
  logic [ID_W-1:0]                  rsp_id;
  logic [FEATURE_WIDTH-1:0]         rsp_data;

  modport master (
    output req_valid, req_feature, req_scaler, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_feature, req_scaler, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );

endinterface

// File: rtl/scaler_rsp_fifo.sv
// Synchronous response FIFO with occupancy count; depth must be a power of two.
module scaler_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 34
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign count   = count_q;
  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign rd_data = mem_q[rd_ptr_q];

  // Next pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write.
  // NOTE: the data array is not reset; every slot is written before count exposes it,
  // and leaving it unreset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) !(rd_en && empty));

endmodule

// File: rtl/scaler_mult_arbiter.sv
// Round-robin sharing of one fixed-latency Q16 scaler multiplier among NUM_REQ
// requesters; results return tagged {id, data} through a credit-protected FIFO.
module scaler_mult_arbiter
  import scaler_pkg::*;
#(
  parameter int NUM_REQ       = DEF_NUM_REQ,
  parameter int FEATURE_WIDTH = DEF_FEATURE_WIDTH,
  parameter int SCALER_WIDTH  = DEF_SCALER_WIDTH,
  parameter int MULT_LATENCY  = 1,
  parameter int OUT_DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  scaler_mult_arbiter_if.slave     bus,
  output logic [FEATURE_WIDTH-1:0] mult_in1,
  output logic [SCALER_WIDTH-1:0]  mult_in2,
  input  logic [FEATURE_WIDTH-1:0] mult_out,
  output logic                     busy
);
  localparam int ID_W  = id_width(NUM_REQ);
  localparam int CRD_W = $clog2(OUT_DEPTH+1);

  typedef logic [ID_W-1:0] id_t;

  typedef struct packed {
    id_t                      id;
    logic [FEATURE_WIDTH-1:0] data;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  // Arbitration state and tag pipe.
  id_t                         rr_ptr_q, rr_ptr_d;
  logic [CRD_W-1:0]            credit_q, credit_d;
  logic [MULT_LATENCY-1:0]     tag_vld_q, tag_vld_d;
  logic [MULT_LATENCY-1:0][ID_W-1:0] tag_id_q, tag_id_d;

  // Combinational arbitration results.
  logic [NUM_REQ-1:0] grant;
  id_t                gid;
  id_t                scan_id;
  logic               issue;

  // FIFO side.
  logic               fifo_wr;
  logic               fifo_rd;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CRD_W-1:0]   fifo_count;
  entry_t             wr_entry;
  entry_t             head;

  // Round-robin pick: first valid requester at or after rr_ptr, only while credit remains.
  // Depends on valid and registered state only, never on operand data.
  // NOTE: every output of this block gets a default before any branch so no latch is inferred.
  always_comb begin
    grant   = '0;
    gid     = '0;
    issue   = 1'b0;
    scan_id = '0;
    if (credit_q != '0) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_id = id_t'((int'(rr_ptr_q) + k) % NUM_REQ);
        if (!issue && bus.req_valid[scan_id]) begin
          issue          = 1'b1;
          gid            = scan_id;
          grant[scan_id] = 1'b1;
        end
      end
    end
  end

  assign bus.req_ready = grant;

  // Operand mux to the shared multiplier; zero when nothing is granted.
  always_comb begin
    mult_in1 = '0;
    mult_in2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        mult_in1 = bus.req_feature[i*FEATURE_WIDTH +: FEATURE_WIDTH];
        mult_in2 = bus.req_scaler[i*SCALER_WIDTH +: SCALER_WIDTH];
      end
    end
  end

  assign fifo_rd = bus.rsp_valid & bus.rsp_ready;
  assign fifo_wr = tag_vld_q[MULT_LATENCY-1];

  // Next-state: pointer advance, credit accounting and tag pipe shift.
  // Credit counts free FIFO slots minus ops in flight, so a pop only frees a slot next cycle.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (issue) rr_ptr_d = (gid == id_t'(NUM_REQ-1)) ? '0 : gid + 1'b1;

    credit_d = credit_q;
    if (issue && !fifo_rd)      credit_d = credit_q - 1'b1;
    else if (!issue && fifo_rd) credit_d = credit_q + 1'b1;

    tag_vld_d    = '0;
    tag_id_d     = '0;
    tag_vld_d[0] = issue;
    tag_id_d[0]  = gid;
    for (int s = 1; s < MULT_LATENCY; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_id_d[s]  = tag_id_q[s-1];
    end
  end

  // Control registers; reset discards in-flight tags so stale mult_out is ignored.
  // NOTE: sequential state uses non-blocking assignments so all flops update from
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      credit_q  <= CRD_W'(OUT_DEPTH);
      tag_vld_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      credit_q  <= credit_d;
      tag_vld_q <= tag_vld_d;
    end
  end

  // Tag ids are qualified by tag_vld_q, so they carry no reset.
  always_ff @(posedge clk) begin
    tag_id_q <= tag_id_d;
  end

  assign wr_entry = '{id: id_t'(tag_id_q[MULT_LATENCY-1]), data: mult_out};

  scaler_rsp_fifo #(
    .DEPTH (OUT_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (fifo_wr),
    .wr_data (wr_entry),
    .rd_en   (fifo_rd),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign bus.rsp_valid = !fifo_empty;
  assign bus.rsp_id    = head.id;
  assign bus.rsp_data  = head.data;
  assign busy          = (|tag_vld_q) | !fifo_empty;

  a_grant_onehot:  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.req_ready));
  a_credit_max:    assert property (@(posedge clk) disable iff (!rst_n) credit_q <= CRD_W'(OUT_DEPTH));
  a_no_wr_full:    assert property (@(posedge clk) disable iff (!rst_n) !(fifo_wr && fifo_full));
  a_credit_conserv: assert property (@(posedge clk) disable iff (!rst_n)
    (int'(credit_q) + int'(fifo_count) + $countones(tag_vld_q)) == OUT_DEPTH);

endmodule

// File: tb/tb_scaler_mult_arbiter.sv
// Directed bench for scaler_mult_arbiter with a Q16 registered-product multiplier model.
module tb_scaler_mult_arbiter;
  import scaler_pkg::*;

  localparam int NR = 4;
  localparam int FW = 32;
  localparam int SW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [FW-1:0] mult_in1;
  logic [SW-1:0] mult_in2;
  logic [FW-1:0] mult_out;
  logic          busy;

  scaler_mult_arbiter_if #(.NUM_REQ(NR), .FEATURE_WIDTH(FW), .SCALER_WIDTH(SW)) bus ();

  scaler_mult_arbiter #(
    .NUM_REQ(NR), .FEATURE_WIDTH(FW), .SCALER_WIDTH(SW), .MULT_LATENCY(1), .OUT_DEPTH(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .mult_in1 (mult_in1),
    .mult_in2 (mult_in2),
    .mult_out (mult_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Multiplier model: signed product, arithmetic shift by FRAC_BITS, one register stage.
  logic signed [63:0] prod;
  assign prod = $signed(mult_in1) * $signed(mult_in2);
  always @(posedge clk) mult_out <= prod[FRAC_BITS +: FW];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [NR-1:0] valid;
    logic          rdy;
    logic [NR-1:0] exp_ready;
    logic          exp_rsp_valid;
    logic [1:0]    exp_id;
    logic          exp_busy;
  } vec_t;

  localparam int NV = 27;
  vec_t          tbl [NV];
  logic [FW-1:0] feat [NR];
  logic [FW-1:0] exp_in1;
  rsp_t          exp_rsp;

  task automatic load_operands();
    for (int r = 0; r < NR; r++) begin
      feat[r] = FW'((r + 1) << 16);
      bus.req_feature[r*FW +: FW] = feat[r];
      bus.req_scaler[r*SW +: SW]  = 32'h0001_0000;
    end
  endtask

  task automatic pulse_reset(input logic [NR-1:0] valid_during);
    rst_n         = 1'b0;
    bus.req_valid = valid_during;
    cyc();
    rst_n         = 1'b1;
    bus.req_valid = '0;
  endtask

  initial begin
    // Round robin, rr_ptr wrap, back-pressure and drain, one record per cycle.
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b0, 2'd0, 1'b1};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd0, 1'b1};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd1, 1'b1};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd2, 1'b1};
    tbl[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b1};
    tbl[6]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b1};
    tbl[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[8]  = '{4'b1000, 1'b1, 4'b1000, 1'b0, 2'd0, 1'b0};
    tbl[9]  = '{4'b1001, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b1};
    tbl[10] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b1};
    tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b1};
    tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[13] = '{4'b1111, 1'b0, 4'b0010, 1'b0, 2'd0, 1'b0};
    tbl[14] = '{4'b1111, 1'b0, 4'b0100, 1'b0, 2'd0, 1'b1};
    tbl[15] = '{4'b1111, 1'b0, 4'b1000, 1'b1, 2'd1, 1'b1};
    tbl[16] = '{4'b1111, 1'b0, 4'b0001, 1'b1, 2'd1, 1'b1};
    tbl[17] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b1};
    tbl[18] = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b1};
    tbl[19] = '{4'b1111, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b1};
    tbl[20] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd2, 1'b1};
    tbl[21] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd3, 1'b1};
    tbl[22] = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd0, 1'b1};
    tbl[23] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b1};
    tbl[24] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b1};
    tbl[25] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b1};
    tbl[26] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};

    rst_n           = 1'b0;
    bus.req_valid   = '0;
    bus.req_feature = '0;
    bus.req_scaler  = '0;
    bus.rsp_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state.
    @(negedge clk);
    check("rst_ready", bus.req_ready, 4'b0000);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_mult_in1", mult_in1, 32'h0);

    // Single op on requester 2: 3.0 * 0.5 = 1.5.
    cyc();
    bus.req_valid               = 4'b0100;
    bus.req_feature[2*FW +: FW] = 32'h0003_0000;
    bus.req_scaler[2*SW +: SW]  = 32'h0000_8000;
    bus.rsp_ready               = 1'b1;
    @(negedge clk);
    check("t1_ready", bus.req_ready, 4'b0100);
    check("t1_in1", mult_in1, 32'h0003_0000);
    check("t1_in2", mult_in2, 32'h0000_8000);
    cyc();
    bus.req_valid = '0;
    @(negedge clk);
    check("t1_no_early_rsp", bus.rsp_valid, 1'b0);
    check("t1_no_grant_in1", mult_in1, 32'h0);
    cyc();
    @(negedge clk);
    exp_rsp = '{id: 2'd2, data: 32'h0001_8000};
    check("t1_rsp_valid", bus.rsp_valid, 1'b1);
    check("t1_rsp", {bus.rsp_id, bus.rsp_data}, exp_rsp);

    // Signed op on requester 1 (rr_ptr now 3, wraps to 1): -2.0 * 1.5 = -3.0.
    cyc();
    bus.req_valid               = 4'b0010;
    bus.req_feature[1*FW +: FW] = 32'hFFFE_0000;
    bus.req_scaler[1*SW +: SW]  = 32'h0001_8000;
    @(negedge clk);
    check("t2_ready", bus.req_ready, 4'b0010);
    cyc();
    bus.req_valid = '0;
    @(negedge clk);
    check("t2_no_early_rsp", bus.rsp_valid, 1'b0);
    cyc();
    @(negedge clk);
    exp_rsp = '{id: 2'd1, data: 32'hFFFD_0000};
    check("t2_rsp_valid", bus.rsp_valid, 1'b1);
    check("t2_rsp", {bus.rsp_id, bus.rsp_data}, exp_rsp);
    cyc();
    @(negedge clk);
    check("t2_idle_busy", busy, 1'b0);

    // Table-driven run from a clean reset.
    cyc();
    pulse_reset('0);
    load_operands();
    for (int i = 0; i < NV; i++) begin
      bus.req_valid = tbl[i].valid;
      bus.rsp_ready = tbl[i].rdy;
      @(negedge clk);
      check($sformatf("v%0d_ready", i), bus.req_ready, tbl[i].exp_ready);
      check($sformatf("v%0d_rsp_valid", i), bus.rsp_valid, tbl[i].exp_rsp_valid);
      check($sformatf("v%0d_busy", i), busy, tbl[i].exp_busy);
      exp_in1 = '0;
      for (int r = 0; r < NR; r++) if (tbl[i].exp_ready[r]) exp_in1 = feat[r];
      check($sformatf("v%0d_in1", i), mult_in1, exp_in1);
      if (tbl[i].exp_rsp_valid) begin
        exp_rsp = '{id: tbl[i].exp_id, data: feat[tbl[i].exp_id]};
        check($sformatf("v%0d_rsp", i), {bus.rsp_id, bus.rsp_data}, exp_rsp);
      end
      cyc();
    end

    // Reset with ops queued and in flight; a grant during the reset cycle leaves a stale mult_out.
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b0;
    cyc();
    cyc();
    cyc();
    @(negedge clk);
    check("t6_pre_rsp_valid", bus.rsp_valid, 1'b1);
    cyc();
    pulse_reset(4'b1111);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("t6_post%0d_rsp_valid", k), bus.rsp_valid, 1'b0);
      check($sformatf("t6_post%0d_busy", k), busy, 1'b0);
      check($sformatf("t6_post%0d_ready", k), bus.req_ready, 4'b0000);
      cyc();
    end
    // Full credit after reset: exactly four grants starting from requester 0.
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("t6_crd%0d_ready", k), bus.req_ready, (k < 4) ? (4'b0001 << k) : 4'b0000);
      cyc();
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      exp_rsp = '{id: 2'(k), data: feat[k]};
      check($sformatf("t6_drain%0d_valid", k), bus.rsp_valid, 1'b1);
      check($sformatf("t6_drain%0d_rsp", k), {bus.rsp_id, bus.rsp_data}, exp_rsp);
      cyc();
    end
    @(negedge clk);
    check("t6_no_stale_rsp", bus.rsp_valid, 1'b0);
    for (int k = 0; k < 20; k++) begin
      if (!busy) break;
      cyc();
    end
    check("t6_drain_busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
